// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 sequential shift-add multiplier with operand holding registers and Busy/Done handshake.
// Optional macro MULT_SIGNED_EN selects two's-complement operands and a signed product.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 EA,
    input  logic                 EB,
    input  logic [WIDTH-1:0]     Data,
    input  logic                 Start,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Q,
    output logic                 Busy,
    output logic                 Done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] sum_next;
    logic               launch;

`ifdef MULT_SIGNED_EN
    logic neg;

    // |v| always fits in WIDTH unsigned bits, including the most-negative value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] s,
                                                      input logic n);
        return n ? -s : s;
    endfunction
`endif

    assign sum_next = acc + (mplier[0] ? mcand : '0);
    assign launch   = Start && (state != RUN);
    assign Busy     = (state == RUN);
    assign Done     = (state == DONE);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            A <= '0;
            B <= '0;
        end else begin
            if (EA) A <= Data;
            if (EB) B <= Data;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            Q      <= '0;
`ifdef MULT_SIGNED_EN
            neg    <= 1'b0;
`endif
        end else if (launch) begin
            // Snapshot the pre-edge operands; later EA/EB loads do not disturb the run.
            state  <= RUN;
            acc    <= '0;
            count  <= CW'(WIDTH);
`ifdef MULT_SIGNED_EN
            mcand  <= {{WIDTH{1'b0}}, magnitude(A)};
            mplier <= magnitude(B);
            neg    <= A[WIDTH-1] ^ B[WIDTH-1];
`else
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
`endif
        end else if (state == RUN) begin
            acc    <= sum_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
            if (count == CW'(1)) begin
`ifdef MULT_SIGNED_EN
                Q <= apply_sign(sum_next, neg);
`else
                Q <= sum_next;
`endif
                state <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed and randomized self-checking bench for seq_shift_add_multiplier (WIDTH=8).
// Honors MULT_SIGNED_EN in its reference model when the macro is defined.
module tb_seq_shift_add_multiplier;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         EA = 1'b0;
    logic         EB = 1'b0;
    logic         Start = 1'b0;
    logic [W-1:0] Data = '0;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2*W-1:0] Q;
    logic         Busy;
    logic         Done;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_q = '0;

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .EA(EA), .EB(EB), .Data(Data), .Start(Start),
        .A(A), .B(B), .Q(Q), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
`ifdef MULT_SIGNED_EN
        p = int'($signed(a)) * int'($signed(b));
`else
        p = int'(a) * int'(b);
`endif
        return p[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] v);
        EA = 1'b1; Data = v;
        step();
        EA = 1'b0;
        check("load_a", A, v);
    endtask

    task automatic load_b(input logic [7:0] v);
        EB = 1'b1; Data = v;
        step();
        EB = 1'b0;
        check("load_b", B, v);
    endtask

    task automatic launch();
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("busy_rise", Busy, 1);
        check("done_low", Done, 0);
    endtask

    // Walks the remaining RUN cycles after launch; optional mid-run EA load and extra Start.
    task automatic expect_done(input logic [15:0] exp, input string tag,
                               input int ea_at, input logic [7:0] ea_val, input int start_at);
        for (int i = 1; i < W; i++) begin
            if (i == ea_at) begin EA = 1'b1; Data = ea_val; end
            if (i == start_at) Start = 1'b1;
            step();
            EA = 1'b0; Start = 1'b0;
            check({tag, "_busy"}, Busy, 1);
            check({tag, "_nodone"}, Done, 0);
            check({tag, "_qhold"}, Q, last_q);
        end
        step();
        check({tag, "_done"}, Done, 1);
        check({tag, "_busyfall"}, Busy, 0);
        check({tag, "_q"}, Q, exp);
        last_q = exp;
    endtask

    task automatic mult(input logic [7:0] a, input logic [7:0] b, input string tag);
        load_a(a);
        load_b(b);
        launch();
        expect_done(ref_mul(a, b), tag, -1, 8'h00, -1);
        step();
        check({tag, "_pulse_end"}, Done, 0);
        check({tag, "_qkeep"}, Q, last_q);
    endtask

    initial begin
        logic [7:0] ra, rb;
        Rst = 1'b1;
        #2 Rst = 1'b0;
        #10;
        check("rst_a", A, 0);
        check("rst_b", B, 0);
        check("rst_q", Q, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        @(posedge Clk); #3 Rst = 1'b1;

        // Basic product and hold afterwards
        load_a(8'd13);
        load_b(8'd11);
        launch();
        expect_done(16'd143, "t1", -1, 8'h00, -1);
        step();
        check("t1_pulse_end", Done, 0);
        check("t1_hold", Q, 16'd143);

        // Max operands, then back-to-back Start in DONE with A reloaded to 0 mid-run
        load_a(8'hFF);
        load_b(8'hFF);
        launch();
        expect_done(ref_mul(8'hFF, 8'hFF), "t2", 2, 8'h00, -1);
`ifdef MULT_SIGNED_EN
        check("t2_const", Q, 16'h0001);
`else
        check("t2_const", Q, 16'hFE01);
`endif
        launch();
        expect_done(16'h0000, "t2b", -1, 8'h00, -1);
        step();
        check("t2b_pulse_end", Done, 0);

        // Extra Start mid-run ignored; mid-run EA load only affects the next Start
        load_a(8'd20);
        load_b(8'd6);
        launch();
        expect_done(ref_mul(8'd20, 8'd6), "t3", 3, 8'd7, 4);
        check("t3_a_new", A, 7);
        step();
        launch();
        expect_done(ref_mul(8'd7, 8'd6), "t3b", -1, 8'h00, -1);
        step();

        // Asynchronous reset in the middle of RUN
        load_a(8'd9);
        load_b(8'd10);
        launch();
        step(); step(); step();
        #2 Rst = 1'b0;
        #1;
        check("ar_a", A, 0);
        check("ar_b", B, 0);
        check("ar_q", Q, 0);
        check("ar_busy", Busy, 0);
        check("ar_done", Done, 0);
        last_q = '0;
        @(posedge Clk); #3 Rst = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            step();
            check("ar_no_done", Done, 0);
            check("ar_idle", Busy, 0);
        end
        mult(8'd3, 8'd4, "post_rst");

`ifdef MULT_SIGNED_EN
        mult(8'hFD, 8'd5, "s1");
        check("s1_const", Q, 16'hFFF1);
        mult(8'h80, 8'h80, "s2");
        check("s2_const", Q, 16'h4000);
        mult(8'h80, 8'h7F, "s3");
        check("s3_const", Q, 16'hC080);
`endif

        // Random sweep, with some back-to-back launches
        for (int n = 0; n < 30; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n % 3 == 0) begin
                ra = (n % 2 == 0) ? 8'h80 : ra;
                rb = (n % 4 == 0) ? 8'hFF : rb;
            end
            mult(ra, rb, "rnd");
        end
        for (int n = 0; n < 6; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            load_a(ra);
            load_b(rb);
            launch();
            expect_done(ref_mul(ra, rb), "b2b_a", -1, 8'h00, -1);
            launch();
            expect_done(ref_mul(ra, rb), "b2b_b", -1, 8'h00, -1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
